// File: rtl/access_control_pkg.sv
// Shared types for the access_control keypad login block: FSM states,
// LCD prompt codes and the user-table record. The LOCKED state only
// exists when ACCESS_LOCKOUT_EN is defined.
package access_control_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_GET_ID,
        ST_GET_PW,
        ST_CHECK,
        ST_GRANTED
`ifdef ACCESS_LOCKOUT_EN
        ,
        ST_LOCKED
`endif
    } state_e;

    localparam logic [1:0] PROMPT_IDLE = 2'd0;
    localparam logic [1:0] PROMPT_ID   = 2'd1;
    localparam logic [1:0] PROMPT_PW   = 2'd2;
    localparam logic [1:0] PROMPT_LOCK = 2'd3;

    typedef struct packed {
        logic        valid;
        logic [15:0] id;
        logic [15:0] pw;
    } user_rec_t;

    localparam int ROM_DEPTH = 4;

    // Fixed credential table, BCD id / BCD password.
    function automatic user_rec_t user_entry(input int idx);
        user_rec_t rec;
        rec = '0;
        case (idx)
            0: rec = '{valid: 1'b1, id: 16'h1234, pw: 16'h0000};
            1: rec = '{valid: 1'b1, id: 16'h2222, pw: 16'h1111};
            2: rec = '{valid: 1'b1, id: 16'h4321, pw: 16'h9876};
            3: rec = '{valid: 1'b1, id: 16'h0007, pw: 16'h5555};
            default: rec = '0;
        endcase
        return rec;
    endfunction

endpackage

// File: rtl/access_control_rom.sv
// access_rom: combinational user-table lookup.
// Ports: i_id, i_pw (BCD, 16b each) in; o_match out.
module access_rom
    import access_control_pkg::*;
#(
    parameter int NUM_USERS = 4
) (
    input  logic [15:0] i_id,
    input  logic [15:0] i_pw,
    output logic        o_match
);

    user_rec_t w_rec;

    always_comb begin
        o_match = 1'b0;
        w_rec   = '0;
        for (int i = 0; i < NUM_USERS; i++) begin
            w_rec = user_entry(i);
            if (w_rec.valid && w_rec.id == i_id && w_rec.pw == i_pw) begin
                o_match = 1'b1;
            end
        end
    end

endmodule

// File: rtl/access_control.sv
// access_control: keypad login FSM (ID, password, check, grant).
// Ports: clk, rst (async active-low), enable, digit_in, digit_valid,
// enter in; access_fb, deny, userid, prompt, digit_cnt out.
// Optional lockout after MAX_TRIES failures: define ACCESS_LOCKOUT_EN.
module access_control
    import access_control_pkg::*;
#(
    parameter int NUM_USERS      = 4,
    parameter int MAX_TRIES      = 3,
    parameter int LOCKOUT_CYCLES = 1000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        enable,
    input  logic [3:0]  digit_in,
    input  logic        digit_valid,
    input  logic        enter,
    output logic        access_fb,
    output logic        deny,
    output logic [15:0] userid,
    output logic [1:0]  prompt,
    output logic [2:0]  digit_cnt
);

    localparam int FW = $clog2(MAX_TRIES + 1);

    state_e          r_state;
    state_e          w_state_n;
    logic [15:0]     r_id;
    logic [15:0]     r_pw;
    logic [15:0]     r_userid;
    logic [2:0]      r_cnt;
    logic            r_deny;
    logic [FW-1:0]   r_fail;
    logic            w_match;
    logic            w_dig_ok;
    logic            w_enter_ok;

`ifdef ACCESS_LOCKOUT_EN
    localparam int LW = $clog2(LOCKOUT_CYCLES);
    logic [LW-1:0]   r_lock_cnt;
    logic            w_lock_done;
    logic            w_last_fail;

    assign w_lock_done = (r_lock_cnt == LW'(LOCKOUT_CYCLES - 1));
    assign w_last_fail = (r_fail >= FW'(MAX_TRIES - 1));
`endif

    access_rom #(
        .NUM_USERS(NUM_USERS)
    ) u_rom (
        .i_id   (r_id),
        .i_pw   (r_pw),
        .o_match(w_match)
    );

    assign w_dig_ok = digit_valid && (digit_in <= 4'd9)
                      && (r_cnt < 3'd4);
    // A digit pulse, even an ignored one, masks enter that cycle.
    assign w_enter_ok = enter && !digit_valid && (r_cnt == 3'd4);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_n;
        end
    end

    always_comb begin
        w_state_n = r_state;
        unique case (r_state)
            ST_IDLE: begin
                if (enable) w_state_n = ST_GET_ID;
            end
            ST_GET_ID: begin
                if (!enable)         w_state_n = ST_IDLE;
                else if (w_enter_ok) w_state_n = ST_GET_PW;
            end
            ST_GET_PW: begin
                if (!enable)         w_state_n = ST_IDLE;
                else if (w_enter_ok) w_state_n = ST_CHECK;
            end
            ST_CHECK: begin
                if (!enable)      w_state_n = ST_IDLE;
                else if (w_match) w_state_n = ST_GRANTED;
`ifdef ACCESS_LOCKOUT_EN
                else if (w_last_fail) w_state_n = ST_LOCKED;
`endif
                else              w_state_n = ST_GET_ID;
            end
            ST_GRANTED: begin
                if (!enable) w_state_n = ST_IDLE;
            end
`ifdef ACCESS_LOCKOUT_EN
            ST_LOCKED: begin
                if (w_lock_done) w_state_n = ST_IDLE;
            end
`endif
            default: w_state_n = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_id     <= '0;
            r_pw     <= '0;
            r_userid <= '0;
            r_cnt    <= '0;
            r_deny   <= 1'b0;
            r_fail   <= '0;
`ifdef ACCESS_LOCKOUT_EN
            r_lock_cnt <= '0;
`endif
        end else begin
            r_deny <= 1'b0;
            unique case (r_state)
                ST_GET_ID, ST_GET_PW: begin
                    if (!enable) begin
                        r_id  <= '0;
                        r_pw  <= '0;
                        r_cnt <= '0;
                    end else if (w_dig_ok) begin
                        if (r_state == ST_GET_ID) r_id <= {r_id[11:0], digit_in};
                        else                      r_pw <= {r_pw[11:0], digit_in};
                        r_cnt <= r_cnt + 3'd1;
                    end else if (w_enter_ok) begin
                        r_cnt <= '0;
                    end
                end
                ST_CHECK: begin
                    if (enable && w_match) begin
                        r_userid <= r_id;
                        r_pw     <= '0;
                        r_fail   <= '0;
                    end else begin
                        r_id <= '0;
                        r_pw <= '0;
                        // Leaving via enable-low is a logout, not a failure.
                        if (enable) begin
                            r_deny <= 1'b1;
                            if (r_fail != FW'(MAX_TRIES)) r_fail <= r_fail + 1'b1;
                        end
                    end
                end
                ST_GRANTED: begin
                    if (!enable) begin
                        r_userid <= '0;
                        r_id     <= '0;
                    end
                end
`ifdef ACCESS_LOCKOUT_EN
                ST_LOCKED: begin
                    if (w_lock_done) begin
                        r_lock_cnt <= '0;
                        r_fail     <= '0;
                    end else begin
                        r_lock_cnt <= r_lock_cnt + 1'b1;
                    end
                end
`endif
                default: ;
            endcase
        end
    end

    always_comb begin
        prompt = PROMPT_IDLE;
        unique case (r_state)
            ST_IDLE, ST_CHECK:     prompt = PROMPT_IDLE;
            ST_GET_ID:             prompt = PROMPT_ID;
            ST_GET_PW, ST_GRANTED: prompt = PROMPT_PW;
`ifdef ACCESS_LOCKOUT_EN
            ST_LOCKED:             prompt = PROMPT_LOCK;
`endif
            default:               prompt = PROMPT_IDLE;
        endcase
    end

    assign access_fb = (r_state == ST_GRANTED);
    assign deny      = r_deny;
    assign userid    = r_userid;
    assign digit_cnt = r_cnt;

endmodule
